// File: rtl/gate_bist_ctrl.sv
// Built-in self-test controller for the two-input basic-gate unit.
// Sweeps {A,B} through 00,01,10,11, holds each vector for SETTLE_CYCLES,
// then compares the unit's seven outputs against the ideal truth table.
// Reports pass/fail, the failing-vector count and the first failure.
// All outputs are registered.

module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 32'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] dut_y,
    output logic       vec_a,
    output logic       vec_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_mask
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Settle counter runs 0..SETTLE_CYCLES-1, i.e. SETTLE_CYCLES APPLY cycles
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);

    // Expected gate-unit word for input vector {A,B}.
    // Bit order: [0]=NOT A, [1]=AND, [2]=OR, [3]=NAND, [4]=NOR, [5]=XOR, [6]=XNOR.
    function automatic logic [6:0] gate_expect(input logic [1:0] vec);
        logic a;
        logic b;
        a = vec[1];
        b = vec[0];
        return {~(a ^ b), (a ^ b), ~(a | b), ~(a & b), (a | b), (a & b), ~a};
    endfunction

    // Registered state
    logic [1:0] state_r;
    logic [1:0] k_r;
    logic [7:0] cnt_r;
    logic [1:0] vec_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_r;
    logic [1:0] fv_r;
    logic [6:0] fm_r;

    // Next-state values
    logic [1:0] state_s;
    logic [1:0] k_s;
    logic [7:0] cnt_s;
    logic [1:0] vec_s;
    logic       busy_s;
    logic       done_s;
    logic       pass_s;
    logic [2:0] err_s;
    logic [1:0] fv_s;
    logic [6:0] fm_s;

    // Comparison of the current vector against the truth table
    logic [6:0] diff_s;
    logic       mism_s;
    logic [2:0] err_chk_s;

    // Mismatch detection and the error count as it stands after this CHECK
    always_comb begin
        diff_s    = gate_expect(k_r) ^ dut_y;
        mism_s    = (diff_s != 7'd0);
        if (mism_s) begin
            err_chk_s = err_r + 3'd1;
        end else begin
            err_chk_s = err_r;
        end
    end

    // Sequencer next-state and output next-value logic
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        cnt_s   = cnt_r;
        vec_s   = vec_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        pass_s  = pass_r;
        err_s   = err_r;
        fv_s    = fv_r;
        fm_s    = fm_r;

        case (state_r)
            ST_IDLE: begin
                vec_s  = 2'b00;
                busy_s = 1'b0;
                if (start) begin
                    // Accept the request: clear the previous run's results
                    state_s = ST_APPLY;
                    k_s     = 2'd0;
                    cnt_s   = 8'd0;
                    vec_s   = 2'b00;
                    busy_s  = 1'b1;
                    pass_s  = 1'b0;
                    err_s   = 3'd0;
                    fv_s    = 2'b00;
                    fm_s    = 7'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_APPLY: begin
                vec_s  = k_r;
                busy_s = 1'b1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end

            ST_CHECK: begin
                err_s = err_chk_s;
                // Only the first failing vector of a run is diagnosed
                if (mism_s && (err_r == 3'd0)) begin
                    fv_s = k_r;
                    fm_s = diff_s;
                end else begin
                    fv_s = fv_r;
                    fm_s = fm_r;
                end
                if (k_r == 2'd3) begin
                    state_s = ST_DONE;
                    vec_s   = 2'b00;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_chk_s == 3'd0);
                end else begin
                    state_s = ST_APPLY;
                    k_s     = k_r + 2'd1;
                    vec_s   = k_r + 2'd1;
                    busy_s  = 1'b1;
                end
            end

            ST_DONE: begin
                // Results stay held; start is not looked at here
                state_s = ST_IDLE;
                vec_s   = 2'b00;
                busy_s  = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                k_s     = 2'd0;
                cnt_s   = 8'd0;
                vec_s   = 2'b00;
                busy_s  = 1'b0;
                pass_s  = 1'b0;
                err_s   = 3'd0;
                fv_s    = 2'b00;
                fm_s    = 7'd0;
            end
        endcase
    end

    // State and output registers; reset aborts a run and clears all results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            k_r     <= 2'd0;
            cnt_r   <= 8'd0;
            vec_r   <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= 3'd0;
            fv_r    <= 2'b00;
            fm_r    <= 7'd0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            cnt_r   <= cnt_s;
            vec_r   <= vec_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            fv_r    <= fv_s;
            fm_r    <= fm_s;
        end
    end

    assign vec_a     = vec_r[1];
    assign vec_b     = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fv_r;
    assign fail_mask = fm_r;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: table of fault scenarios, random
// fault scenarios checked against a result model, and hand-written
// sequences for held start and mid-run reset.

module tb_gate_bist_ctrl;

    localparam int S       = 2;
    localparam int BUSY_N  = 4 * (S + 1);
    localparam int RUN_LEN = 4 * (S + 1) + 1;

    typedef struct packed {
        logic [2:0] err;
        logic [1:0] fv;
        logic [6:0] fm;
        logic       pass;
    } res_t;

    typedef struct packed {
        logic [3:0][6:0] flt;     // XOR fault applied to the unit output per vector
        logic            glitch;  // drive 7'h7F during settle cycles
        res_t            exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] dut_y;
    logic       vec_a;
    logic       vec_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] fail_vec;
    logic [6:0] fail_mask;

    int total;
    int passed;

    // Ideal unit outputs indexed by {A,B}; bits [6:0] = XNY,XY,NOY,NAY,OY,AY,NY
    logic [6:0] tt [4];

    gate_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_y     (dut_y),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec),
        .fail_mask (fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Result model: count failing vectors, diagnose the lowest-numbered one
    function automatic res_t model(input logic [3:0][6:0] flt);
        res_t r;
        r.err  = 3'd0;
        r.fv   = 2'b00;
        r.fm   = 7'd0;
        for (int v = 0; v < 4; v++) begin
            if (flt[v] != 7'd0) begin
                if (r.err == 3'd0) begin
                    r.fv = v[1:0];
                    r.fm = flt[v];
                end
                r.err = r.err + 3'd1;
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    // One complete run starting at the next accept edge; leaves the bench in
    // the first IDLE cycle after done
    task automatic run_test(input string name, input logic [3:0][6:0] flt,
                            input logic glitch, input logic hold, input res_t exp);
        int  k;
        bit  in_chk;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= RUN_LEN; c++) begin
            #1;
            if (!hold) start = 1'b0;
            k      = (c - 1) / (S + 1);
            in_chk = (c == (k + 1) * (S + 1));
            if (c <= BUSY_N) begin
                if (in_chk)      dut_y = tt[k] ^ flt[k];
                else if (glitch) dut_y = 7'h7F;
                else             dut_y = 7'($urandom);
            end else begin
                dut_y = 7'($urandom);
            end
            chk({name, ".busy"}, 32'(busy), 32'(c <= BUSY_N));
            chk({name, ".done"}, 32'(done), 32'(c == RUN_LEN));
            chk({name, ".vec"}, 32'({vec_a, vec_b}), (c <= BUSY_N) ? 32'(k) : 32'd0);
            if (c == 1) begin
                chk({name, ".clr_err"}, 32'(err_count), 32'd0);
                chk({name, ".clr_pass"}, 32'(pass), 32'd0);
                chk({name, ".clr_mask"}, 32'(fail_mask), 32'd0);
            end
            if (c < RUN_LEN) @(posedge clk);
        end
        chk({name, ".pass"}, 32'(pass), 32'(exp.pass));
        chk({name, ".err_count"}, 32'(err_count), 32'(exp.err));
        chk({name, ".fail_vec"}, 32'(fail_vec), 32'(exp.fv));
        chk({name, ".fail_mask"}, 32'(fail_mask), 32'(exp.fm));
        @(posedge clk);
        #1;
        chk({name, ".idle_done"}, 32'(done), 32'd0);
        chk({name, ".idle_busy"}, 32'(busy), 32'd0);
        chk({name, ".hold_pass"}, 32'(pass), 32'(exp.pass));
        chk({name, ".hold_err"}, 32'(err_count), 32'(exp.err));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".busy"}, 32'(busy), 32'd0);
        chk({name, ".done"}, 32'(done), 32'd0);
        chk({name, ".pass"}, 32'(pass), 32'd0);
        chk({name, ".err"}, 32'(err_count), 32'd0);
        chk({name, ".fv"}, 32'(fail_vec), 32'd0);
        chk({name, ".fm"}, 32'(fail_mask), 32'd0);
        chk({name, ".vec"}, 32'({vec_a, vec_b}), 32'd0);
    endtask

    initial begin
        vec_t            tbl [5];
        logic [3:0][6:0] flt;
        logic [3:0][6:0] ok;
        res_t            good;

        total  = 0;
        passed = 0;
        tt[0]  = 7'b1011001;
        tt[1]  = 7'b0101101;
        tt[2]  = 7'b0101100;
        tt[3]  = 7'b1000110;
        ok     = '0;
        good   = '{err: 3'd0, fv: 2'b00, fm: 7'd0, pass: 1'b1};

        tbl[0] = '{flt: {7'd0, 7'd0, 7'd0, 7'd0}, glitch: 1'b0,
                   exp: '{err: 3'd0, fv: 2'b00, fm: 7'd0, pass: 1'b1}};
        // AY stuck-at-0: only vector 11 differs, in AY
        tbl[1] = '{flt: {7'b0000010, 7'd0, 7'd0, 7'd0}, glitch: 1'b0,
                   exp: '{err: 3'd1, fv: 2'b11, fm: 7'b0000010, pass: 1'b0}};
        // NY inverted on every vector
        tbl[2] = '{flt: {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, glitch: 1'b0,
                   exp: '{err: 3'd4, fv: 2'b00, fm: 7'b0000001, pass: 1'b0}};
        // Wrong during settling only
        tbl[3] = '{flt: {7'd0, 7'd0, 7'd0, 7'd0}, glitch: 1'b1,
                   exp: '{err: 3'd0, fv: 2'b00, fm: 7'd0, pass: 1'b1}};
        // Failures on 01 and 10; 01 is diagnosed
        tbl[4] = '{flt: {7'd0, 7'h01, 7'h44, 7'd0}, glitch: 1'b1,
                   exp: '{err: 3'd2, fv: 2'b01, fm: 7'h44, pass: 1'b0}};

        rst_n = 1'b0;
        start = 1'b0;
        dut_y = 7'd0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_test($sformatf("tbl%0d", i), tbl[i].flt, tbl[i].glitch, 1'b0, tbl[i].exp);
        end

        // Randomized fault scenarios
        for (int i = 0; i < 12; i++) begin
            for (int v = 0; v < 4; v++) begin
                flt[v] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            end
            run_test($sformatf("rnd%0d", i), flt, 1'($urandom_range(0, 1)), 1'b0, model(flt));
        end

        // start held high: back-to-back runs, results cleared at each accept
        run_test("hold0", tbl[2].flt, 1'b0, 1'b1, tbl[2].exp);
        run_test("hold1", ok, 1'b0, 1'b1, good);
        run_test("hold2", tbl[1].flt, 1'b0, 1'b0, tbl[1].exp);
        start = 1'b0;

        // Reset in cycle 5 of a run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("midrun.busy_before", 32'(busy), 32'd1);
        chk("midrun.vec_before", 32'({vec_a, vec_b}), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        @(negedge clk);
        #1;
        chk_all_zero("midrun_rst_held");
        rst_n = 1'b1;
        run_test("after_rst", ok, 1'b1, 1'b0, good);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test controller for the two-input basic-gate unit, which has seven outputs: NOT, AND, OR, NAND, NOR, XOR and XNOR. On request it sweeps the unit's A/B inputs through all four input combinations, waits a programmable settle time for each, and compares the unit's outputs against an internal truth table. It reports pass/fail, the number of failing vectors, and a diagnosis of the first failure. It sits beside the gate unit and owns that unit's A/B inputs while a test is running.

## Interface
- SETTLE_CYCLES, default 2: cycles each vector is held before its outputs are checked. Legal range is 1 to 255; 0 is illegal.
- clk  in  1  : single clock; all flops are rising-edge.
- rst_n  in  1  : asynchronous active-low reset.
- start  in  1  : test request; sampled only in IDLE.
- dut_y  in  7  : gate unit outputs, bit-packed as [0]=NY, [1]=AY, [2]=OY, [3]=NAY, [4]=NOY, [5]=XY, [6]=XNY.
- vec_a  out  1  : drives gate input A.
- vec_b  out  1  : drives gate input B.
- busy  out  1  : high while in APPLY or CHECK.
- done  out  1  : one-cycle pulse at the end of a run.
- pass  out  1  : 1 when the last run had zero failing vectors; held until the next start is accepted.
- err_count  out  3  : number of failing vectors in the run, 0 to 4.
- fail_vec  out  2  : {A,B} of the first failing vector.
- fail_mask  out  7  : expected XOR observed for the first failing vector; 0 if no failure.

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- IDLE, start=1: go to APPLY with vector index k=0.
  - On that same edge, clear err_count, fail_vec, fail_mask and pass to 0.
- APPLY:
  - Drive {vec_a,vec_b}=k.
  - The settle counter counts 1..SETTLE_CYCLES; after SETTLE_CYCLES cycles in APPLY, go to CHECK.
- CHECK:
  - Vector stays driven.
  - dut_y is compared with the expected word for k: NY=~A, AY=A&B, OY=A|B, NAY=~(A&B), NOY=~(A|B), XY=A^B, XNY=~(A^B).
  - On mismatch, err_count increments; if this is the first mismatch of the run, fail_vec=k and fail_mask=expected^dut_y are captured.
  - If k<3: k increments, go to APPLY. If k=3: go to DONE.
- Vector order is fixed: 00, 01, 10, 11. k does not wrap within a run.
- DONE:
  - done=1 and busy=0.
  - pass is registered as (final err_count==0), including a mismatch found on the last CHECK.
  - Unconditionally return to IDLE next cycle.
- vec_a and vec_b are 0 in IDLE and DONE.
- dut_y is ignored in every state except CHECK, so glitches during settling are tolerated.
- start is ignored in APPLY, CHECK and DONE; no request is queued. If start is still high in IDLE, a new run begins.
- Reset, asynchronous and at any time:
  - State goes to IDLE.
  - All outputs go to 0: busy, done, pass, err_count, fail_vec, fail_mask, vec_a, vec_b.
  - The settle counter and k go to 0.
  - A run aborted by reset reports nothing.

## Timing
- Cycle 0 is the edge at which start is accepted in IDLE. Let S = SETTLE_CYCLES.
- Vector k is driven in cycles k(S+1)+1 through (k+1)(S+1). Its CHECK is cycle (k+1)(S+1); dut_y is sampled on the rising edge that ends that cycle.
- busy is high in cycles 1 through 4(S+1).
- done pulses in cycle 4(S+1)+1. pass, err_count, fail_vec and fail_mask are stable from that cycle onward.
- With the default S=2: busy is high in cycles 1-12, done is in cycle 13, and the earliest re-accept of start is cycle 14.
- Gate-unit propagation plus routing must settle within S cycles; S is sized by the integrator.

## Test plan
- Correct combinational gate model, S=2, start pulse at cycle 0:
  - busy high in cycles 1-12, done in cycle 13.
  - pass=1, err_count=0, fail_mask=7'b0000000.
  - vec sequence 00,01,10,11, each held 3 cycles.
- AY stuck-at-0:
  - Only vector 11 fails.
  - pass=0, err_count=1, fail_vec=2'b11, fail_mask=7'b0000010.
- NY inverted (wrong on all vectors):
  - err_count=4, fail_vec=2'b00, fail_mask=7'b0000001, pass=0.
- start held high continuously:
  - Exactly one run per IDLE visit; done pulses every 14 cycles.
  - start is not sampled while busy; results are cleared at each re-accept.
- rst_n pulled low in cycle 5 of a run:
  - All outputs are 0 immediately, with no clock needed.
  - After release, a new start runs the full 4-vector sequence and done lands 13 cycles later.
- dut_y driven to 7'h7F (wrong) during every APPLY cycle and correct during every CHECK cycle:
  - pass=1, err_count=0.
